dm_wait: RTL and testbench
==========================

Name: dm_wait

Overview:
- Parametrised successor to the single-cycle byte-addressed data memory.
- Byte-addressed, big-endian data memory with byte, half and word accesses, and sign or zero extension on loads.
- Misaligned and illegal-size accesses are detected and reported.
- A valid/ready request handshake with a programmable number of wait states lets the CPU pipeline model a slow memory stage (stall while req_ready is low).

Parameters:
- ADDR_W, 8, byte-address bits actually decoded; capacity = 2**ADDR_W bytes (must be ≥2).
- WAIT_CYCLES, 2, wait states between request acceptance and the access edge (0 allowed).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address; bits above ADDR_W ignored (wrap modulo capacity)
- req_wdata  in  32  store data, right-justified (byte = [7:0], half = [15:0])
- resp_valid  out  1  one-cycle pulse: access completed
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size, valid with resp_valid

Behaviour:
- Reset synchronous, active-high: state = IDLE, counter = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Memory array is not cleared by rst. It is zero at time 0 (initial block). A reset mid-operation abandons the pending request; a store whose access edge has not occurred is never committed.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, all req_* are latched. Next state is WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0, otherwise the access is performed on this same edge and next state is RESP.
  - WAIT: req_ready = 0. Counter decrements each cycle. When counter = 0, the access is performed on that edge and next state is RESP.
  - RESP: req_ready = 0, resp_valid = 1 for exactly one cycle, then IDLE. A new request cannot be accepted in RESP.
- Latency: request accepted at edge N → resp_valid high in the cycle after edge N+WAIT_CYCLES. Max throughput is one access per WAIT_CYCLES+2 cycles.
- Access edge:
  - resp_rdata and resp_err registered; the memory write occurs on the same edge.
  - Outputs hold their values through RESP; they are cleared to 0 on leaving RESP.
- Alignment:
  - Half requires addr[0] = 0. Word requires addr[1:0] = 00. size = 11 is always an error.
  - On error: no memory write, resp_rdata = 0, resp_err = 1.
- Endianness: big-endian. Byte at A holds the most significant byte.
  - Word: {M[A], M[A+1], M[A+2], M[A+3]}.
  - Half: {M[A], M[A+1]}.
  - Stores write only the addressed bytes (byte = 1 lane, half = 2, word = 4); other bytes are unchanged.
- Loads: the byte or half is sign-extended from bit 7 or 15 unless req_unsigned = 1. Word loads ignore req_unsigned.
- Inputs are sampled only in IDLE with req_valid = 1. Changes on req_* while busy have no effect.
- Address wrap: the aligned access lies fully inside capacity, so no wrap occurs within one access. The top address bits are simply discarded.

Decomposition:
- Shared package dm_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL
  - FSM state enum S_IDLE/S_WAIT/S_RESP
  - function align_ok(size, addr[1:0])
- One natural sub-module, dm_lane: combinational byte-lane steering and extension. It maps (size, addr[1:0], unsigned, wdata, 32-bit aligned read word) to a 4-bit byte-write mask, 4 lane bytes and the extended load result.
- The top level holds the FSM, counter, request latch and byte array.

Test Plan:
- Word store/load, WAIT_CYCLES=2: store 0xDEADBEEF to addr 0x10, then load word at 0x10. Expect rdata = 0xDEADBEEF, M[0x10] = 0xDE, and resp_valid exactly 3 cycles after each accept edge; req_ready low for 3 cycles.
- Byte extension: after the above, signed byte load at 0x10 → 0xFFFFFFDE; unsigned byte load → 0x000000DE; signed half load at 0x12 → 0xFFFFBEEF.
- Partial store: store half 0x1234 at 0x12, then load word at 0x10 → 0xDEAD1234 (bytes 0x10–0x11 untouched).
- Misalignment: store word 0xFFFFFFFF at 0x11 → resp_err = 1, rdata = 0. Next load word at 0x10 is unchanged. Also size = 11 → resp_err = 1.
- Reset mid-operation: accept store 0x55 byte at 0x20, assert rst during WAIT. Expect no commit (later load → 0), req_ready = 1 and resp_valid = 0 the cycle after rst.
- WAIT_CYCLES=0 plus wrap (ADDR_W=8): store byte 0xA5 at 0x00000105, load byte at 0x05 → 0xFFFFFFA5. resp_valid appears the cycle after acceptance; back-to-back req_valid is accepted every 2 cycles.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the wait-state data memory.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Natural alignment check; the illegal size never passes.
    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] a);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (a[0] == 1'b0);
            SZ_WORD: ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_wait_lane.sv
// Big-endian byte-lane steering: store lane data/mask and load extraction
// with sign or zero extension. Lane 0 is the lowest address of the word.
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic [1:0]      off_i,
    input  logic            uns_i,
    input  logic [31:0]     wdata_i,
    input  logic [31:0]     rword_i,
    output logic [3:0]      be_o,
    output logic [0:3][7:0] wbyte_o,
    output logic [31:0]     rdata_o
);

    logic [0:3][7:0] rb;
    logic [7:0]      b;
    logic [15:0]     h;

    // Lane 0 sits in the most significant byte of the aligned read word.
    assign rb = rword_i;

    // Steer write lanes and extract/extend the loaded byte or half.
    always_comb begin
        be_o    = '0;
        wbyte_o = '0;
        rdata_o = '0;
        b       = '0;
        h       = '0;
        case (size_i)
            SZ_BYTE: begin
                be_o[3 - off_i]  = 1'b1;
                wbyte_o[off_i]   = wdata_i[7:0];
                b                = rb[off_i];
                rdata_o          = uns_i ? {24'h0, b} : {{24{b[7]}}, b};
            end
            SZ_HALF: begin
                be_o[3 - {off_i[1], 1'b0}] = 1'b1;
                be_o[3 - {off_i[1], 1'b1}] = 1'b1;
                wbyte_o[{off_i[1], 1'b0}]  = wdata_i[15:8];
                wbyte_o[{off_i[1], 1'b1}]  = wdata_i[7:0];
                h       = {rb[{off_i[1], 1'b0}], rb[{off_i[1], 1'b1}]};
                rdata_o = uns_i ? {16'h0, h} : {{16{h[15]}}, h};
            end
            SZ_WORD: begin
                be_o    = 4'hF;
                wbyte_o = wdata_i;
                rdata_o = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_wait.sv
// Byte-addressed big-endian data memory behind a valid/ready request
// handshake with a fixed number of wait states before the access edge.
module dm_wait
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              latch, access;

    logic [7:0]        mem [DEPTH];

    // Operands of the access: live inputs when the access happens on the
    // accept edge (no wait states), otherwise the latched request.
    logic              idle;
    logic              a_we, a_uns, a_ok;
    logic [1:0]        a_size;
    logic [ADDR_W-1:0] a_addr, base;
    logic [31:0]       a_wdata, rword, lane_rdata;
    logic [3:0]        be;
    logic [0:3][7:0]   wbyte;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W];

    assign idle    = (state_q == S_IDLE);
    assign a_we    = idle ? req_we                     : we_q;
    assign a_uns   = idle ? req_unsigned               : uns_q;
    assign a_size  = idle ? req_size                   : size_q;
    assign a_addr  = idle ? req_addr[ADDR_W-1:0]       : addr_q;
    assign a_wdata = idle ? req_wdata                  : wdata_q;
    assign a_ok    = align_ok(a_size, a_addr[1:0]);
    assign base    = a_addr & ~(ADDR_W'(3));

    assign rword = {mem[base], mem[base + ADDR_W'(1)],
                    mem[base + ADDR_W'(2)], mem[base + ADDR_W'(3)]};

    dm_lane u_lane (
        .size_i  (a_size),
        .off_i   (a_addr[1:0]),
        .uns_i   (a_uns),
        .wdata_i (a_wdata),
        .rword_i (rword),
        .be_o    (be),
        .wbyte_o (wbyte),
        .rdata_o (lane_rdata)
    );

    assign req_ready  = idle;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next-state logic: accept in IDLE, count down wait states, pulse RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, request latch and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
            end
            if (access) begin
                rdata_q <= (a_ok && !a_we) ? lane_rdata : 32'h0;
                err_q   <= !a_ok;
            end else if (state_q == S_RESP) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Byte array: written only on a good store's access edge; reset on the
    // same edge abandons the store. Contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && access && a_ok && a_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[3 - k]) mem[base + ADDR_W'(k)] <= wbyte[k];
            end
        end
    end

endmodule

// File: tb/tb_dm_wait.sv
// Directed checks of dm_wait: one instance with two wait states, one with none.
module tb_dm_wait;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0, vb = 1'b0;
    logic        we = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        rdy_a, rv_a, err_a, rdy_b, rv_b, err_b;
    logic [31:0] rd_a, rd_b;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    dm_wait #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_ready(rdy_a), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(err_a));

    dm_wait #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rdy_b), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(err_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on instance sel; checks latency, busy window, result, clear.
    task automatic txn(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int wc, input string tag);
        int lat, busy;
        @(negedge clk);
        we = w; size = sz; uns = u; addr = ad; wdata = wd;
        if (sel) vb = 1'b1; else va = 1'b1;
        chk({tag, ".ready"}, {31'b0, sel ? rdy_b : rdy_a}, 32'd1);
        @(posedge clk);
        #1;
        va = 1'b0; vb = 1'b0;
        // Scramble inputs while busy; the latched request must be used.
        we = ~w; size = 2'b11; addr = 32'hFF; wdata = 32'h0BAD0BAD;
        lat = 0; busy = 0;
        @(negedge clk);
        while (!(sel ? rv_b : rv_a) && lat < 20) begin
            if (!(sel ? rdy_b : rdy_a)) busy++;
            lat++;
            @(negedge clk);
        end
        if (!(sel ? rdy_b : rdy_a)) busy++;
        chk({tag, ".lat"},   lat,  wc);
        chk({tag, ".busy"},  busy, wc + 1);
        chk({tag, ".rdata"}, sel ? rd_b : rd_a, exp_rd);
        chk({tag, ".err"},   {31'b0, sel ? err_b : err_a}, {31'b0, exp_err});
        @(negedge clk);
        chk({tag, ".clr"}, {sel ? rv_b : rv_a, sel ? rdy_b : rdy_a, sel ? err_b : err_a},
            {1'b0, 1'b1, 1'b0});
        chk({tag, ".clrd"}, sel ? rd_b : rd_a, 32'h0);
    endtask

    initial begin
        int acc, pulses;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.a", {rdy_a, rv_a, err_a}, {1'b1, 1'b0, 1'b0});
        chk("rst.a.rd", rd_a, 32'h0);
        chk("rst.b", {rdy_b, rv_b, err_b}, {1'b1, 1'b0, 1'b0});

        // Word store/load and lane extraction, two wait states.
        txn(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, "st_w");
        txn(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, "ld_w");
        txn(0, 0, 2'b00, 0, 32'h10, 32'h0,        32'hFFFFFFDE, 0, 2, "ld_bs");
        txn(0, 0, 2'b00, 1, 32'h10, 32'h0,        32'h000000DE, 0, 2, "ld_bu");
        txn(0, 0, 2'b00, 1, 32'h13, 32'h0,        32'h000000EF, 0, 2, "ld_b3");
        txn(0, 0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFFBEEF, 0, 2, "ld_hs");
        txn(0, 0, 2'b01, 1, 32'h10, 32'h0,        32'h0000DEAD, 0, 2, "ld_hu");
        // Partial store leaves the other half alone.
        txn(0, 1, 2'b01, 0, 32'h12, 32'h00001234, 32'h0,        0, 2, "st_h");
        txn(0, 0, 2'b10, 1, 32'h10, 32'h0,        32'hDEAD1234, 0, 2, "ld_w2");
        txn(0, 1, 2'b00, 0, 32'h11, 32'h000000C3, 32'h0,        0, 2, "st_b");
        txn(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEC31234, 0, 2, "ld_w3");
        // Errors: misaligned word store, misaligned half, illegal size.
        txn(0, 1, 2'b10, 0, 32'h11, 32'hFFFFFFFF, 32'h0,        1, 2, "mis_w");
        txn(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEC31234, 0, 2, "ld_w4");
        txn(0, 0, 2'b01, 0, 32'h11, 32'h0,        32'h0,        1, 2, "mis_h");
        txn(0, 0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 2, "ill");

        // Reset during WAIT abandons a store.
        txn(0, 1, 2'b00, 0, 32'h20, 32'h0,        32'h0,        0, 2, "st_z");
        @(negedge clk);
        we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h20; wdata = 32'h55; va = 1'b1;
        @(posedge clk);
        #1 va = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {rdy_a, rv_a, err_a}, {1'b1, 1'b0, 1'b0});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.idle", {rdy_a, rv_a}, {1'b1, 1'b0});
        txn(0, 0, 2'b00, 0, 32'h20, 32'h0,        32'h0,        0, 2, "ld_z");

        // No wait states, address wrap modulo 256.
        txn(1, 1, 2'b00, 0, 32'h105, 32'h000000A5, 32'h0,        0, 0, "b_st");
        txn(1, 0, 2'b00, 0, 32'h05,  32'h0,        32'hFFFFFFA5, 0, 0, "b_ld");

        // Back-to-back: held valid is accepted every other cycle.
        @(negedge clk);
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h05; vb = 1'b1;
        acc = 0; pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (rdy_b) acc++;
            if (rv_b && rd_b == 32'hFFFFFFA5) pulses++;
            @(negedge clk);
        end
        vb = 1'b0;
        chk("b2b.acc",   acc,    3);
        chk("b2b.pulse", pulses, 3);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
